// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin front end for the shared 16-bit ALU: sequences the
// operand/result load enables, waits out the settle window, and returns the result.
module alu_op_scheduler #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_cb,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [15:0]      rsp_remainder,
  output logic [3:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [15:0]      alu_d_a,
  output logic [15:0]      alu_d_b,
  output logic [1:0]       alu_op_code,
  output logic             alu_en_a,
  output logic             alu_en_b,
  output logic             alu_en_result,
  output logic             alu_cin,
  output logic             alu_bin,
  input  logic [31:0]      alu_result,
  input  logic [15:0]      alu_remainder,
  input  logic             alu_cout,
  input  logic             alu_bout,
  input  logic             alu_overflow,
  input  logic             alu_error
);

  localparam int DATA_W = 16;
  localparam int SCNT_W = 4;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    SETTLE,
    RESP
  } state_t;

  state_t              state;
  logic                prio;
  logic                gnt;
  logic [SCNT_W-1:0]   settle_cnt;

  logic                gnt_sel;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_cb;

  // On a tie the preferred requester wins; otherwise whichever one is asking.
  function automatic logic pick_grant(input logic [1:0] valid, input logic pref);
    if (valid == 2'b11) return pref;
    return valid[1];
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    gnt_sel = pick_grant(req_valid, prio);
    sel_op  = gnt_sel ? req_op[3:2]   : req_op[1:0];
    sel_a   = gnt_sel ? req_a[31:16]  : req_a[15:0];
    sel_b   = gnt_sel ? req_b[31:16]  : req_b[15:0];
    sel_cb  = gnt_sel ? req_cb[1]     : req_cb[0];
  end

  // Accept is combinational in IDLE and forced low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (rstn && (state == IDLE) && (req_valid != 2'b00))
      req_ready = onehot(gnt_sel);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      prio          <= 1'b0;
      gnt           <= 1'b0;
      settle_cnt    <= '0;
      alu_d_a       <= '0;
      alu_d_b       <= '0;
      alu_op_code   <= '0;
      alu_cin       <= 1'b0;
      alu_bin       <= 1'b0;
      alu_en_a      <= 1'b0;
      alu_en_b      <= 1'b0;
      alu_en_result <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_flags     <= '0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            gnt         <= gnt_sel;
            prio        <= ~gnt_sel;
            alu_d_a     <= sel_a;
            alu_d_b     <= sel_b;
            alu_op_code <= sel_op;
            alu_cin     <= sel_cb & (sel_op == 2'b00);
            alu_bin     <= sel_cb & (sel_op == 2'b01);
            alu_en_a    <= 1'b1;
            alu_en_b    <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          alu_en_a      <= 1'b0;
          alu_en_b      <= 1'b0;
          alu_en_result <= 1'b1;
          state         <= EXEC;
        end
        EXEC: begin
          alu_en_result <= 1'b0;
          settle_cnt    <= '0;
          state         <= SETTLE;
        end
        // Result is sampled on the SETTLE_CYCLES-th edge after entering SETTLE.
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            rsp_result    <= alu_result;
            rsp_remainder <= alu_remainder;
            rsp_flags     <= {alu_error, alu_overflow, alu_bout, alu_cout};
            rsp_valid     <= onehot(gnt);
            state         <= RESP;
          end else begin
            settle_cnt <= settle_cnt + SCNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid   <= 2'b00;
            op_count    <= op_count + CNT_W'(1);
            alu_d_a     <= '0;
            alu_d_b     <= '0;
            alu_op_code <= '0;
            alu_cin     <= 1'b0;
            alu_bin     <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a small behavioural ALU model
// attached to the alu_* interface.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  req_cb = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_result;
  logic [15:0] rsp_remainder;
  logic [3:0]  rsp_flags;
  logic        busy;
  logic [15:0] op_count;
  logic [15:0] alu_d_a, alu_d_b;
  logic [1:0]  alu_op_code;
  logic        alu_en_a, alu_en_b, alu_en_result, alu_cin, alu_bin;
  logic [31:0] alu_result = '0;
  logic [15:0] alu_remainder = '0;
  logic        alu_cout = 1'b0, alu_bout = 1'b0, alu_overflow = 1'b0, alu_error = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  alu_op_scheduler #(.SETTLE_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cb(req_cb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_remainder(rsp_remainder), .rsp_flags(rsp_flags),
    .busy(busy), .op_count(op_count),
    .alu_d_a(alu_d_a), .alu_d_b(alu_d_b), .alu_op_code(alu_op_code),
    .alu_en_a(alu_en_a), .alu_en_b(alu_en_b), .alu_en_result(alu_en_result),
    .alu_cin(alu_cin), .alu_bin(alu_bin),
    .alu_result(alu_result), .alu_remainder(alu_remainder),
    .alu_cout(alu_cout), .alu_bout(alu_bout),
    .alu_overflow(alu_overflow), .alu_error(alu_error)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: operand registers load on en_a/en_b, result register on en_result.
  logic [15:0] m_a = '0, m_b = '0;
  logic [1:0]  m_op = '0;
  logic        m_cin = 1'b0, m_bin = 1'b0;
  logic [16:0] c_s;
  logic [31:0] c_res;
  logic [15:0] c_rem;
  logic        c_cout, c_bout, c_ovf, c_err;

  always_comb begin
    c_s = '0; c_res = '0; c_rem = '0;
    c_cout = 1'b0; c_bout = 1'b0; c_ovf = 1'b0; c_err = 1'b0;
    case (m_op)
      2'b00: begin
        c_s    = {1'b0, m_a} + {1'b0, m_b} + {16'd0, m_cin};
        c_res  = {16'd0, c_s[15:0]};
        c_cout = c_s[16];
        c_ovf  = (m_a[15] == m_b[15]) && (c_s[15] != m_a[15]);
      end
      2'b01: begin
        c_s    = {1'b0, m_a} - {1'b0, m_b} - {16'd0, m_bin};
        c_res  = {16'd0, c_s[15:0]};
        c_bout = c_s[16];
        c_ovf  = (m_a[15] != m_b[15]) && (c_s[15] != m_a[15]);
      end
      2'b10: c_res = {16'd0, m_a} * {16'd0, m_b};
      default: begin
        if (m_b == 16'd0) c_err = 1'b1;
        else begin
          c_res = {16'd0, m_a / m_b};
          c_rem = m_a % m_b;
        end
      end
    endcase
  end

  always @(posedge clk) begin
    if (alu_en_a) begin
      m_a <= alu_d_a; m_op <= alu_op_code; m_cin <= alu_cin; m_bin <= alu_bin;
    end
    if (alu_en_b) m_b <= alu_d_b;
    if (alu_en_result) begin
      alu_result <= c_res; alu_remainder <= c_rem;
      alu_cout <= c_cout; alu_bout <= c_bout; alu_overflow <= c_ovf; alu_error <= c_err;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cb);
    req_op[2*r +: 2]  = op;
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
    req_cb[r]         = cb;
    req_valid[r]      = 1'b1;
  endtask

  task automatic wait_rsp(input int maxc);
    int c = 0;
    while (rsp_valid == 2'b00 && c < maxc) begin
      tick;
      c++;
    end
    chk("rsp_wait", 64'(rsp_valid != 2'b00), 64'd1);
  endtask

  int grants[4];
  int ng;
  int lowc;

  initial begin
    // Reset state
    repeat (2) tick;
    chk("rst_valid", {rsp_valid, req_ready, busy}, 5'b0);
    chk("rst_alu", {alu_en_a, alu_en_b, alu_en_result, alu_d_a, alu_d_b}, 35'd0);
    chk("rst_count", op_count, 16'd0);
    rstn = 1'b1;
    tick;

    // Test 1: req0 add 100+200, cycle-exact enables
    issue(0, 2'b00, 16'd100, 16'd200, 1'b0);
    #1 chk("t1_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    chk("t1_E0_en", {alu_en_a, alu_en_b, alu_en_result, busy, req_ready}, 6'b110100);
    chk("t1_E0_d", {alu_d_a, alu_d_b}, {16'd100, 16'd200});
    tick;
    chk("t1_E1_en", {alu_en_a, alu_en_b, alu_en_result}, 3'b001);
    tick;
    chk("t1_E2_en", {alu_en_a, alu_en_b, alu_en_result}, 3'b000);
    tick;
    chk("t1_E3_vld", rsp_valid, 2'b00);
    tick;
    chk("t1_E4_vld", rsp_valid, 2'b01);
    chk("t1_res", {rsp_result, rsp_flags}, {32'd300, 4'b0000});
    rsp_ready = 2'b01;
    tick;
    chk("t1_done", {rsp_valid, busy, op_count}, {2'b00, 1'b0, 16'd1});
    rsp_ready = 2'b00;

    // Test 2: simultaneous requests right after reset
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    tick;
    issue(0, 2'b10, 16'd1000, 16'd1000, 1'b0);
    issue(1, 2'b01, 16'd100, 16'd200, 1'b0);
    #1 chk("t2_ready0", req_ready, 2'b01);
    tick;
    req_valid[0] = 1'b0;
    wait_rsp(20);
    chk("t2_rsp0", {rsp_valid, rsp_result}, {2'b01, 32'd1000000});
    rsp_ready = 2'b11;
    tick;
    #1 chk("t2_ready1", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    wait_rsp(20);
    chk("t2_rsp1", {rsp_valid, rsp_result[15:0], rsp_flags}, {2'b10, 16'hFF9C, 4'b0010});
    tick;
    chk("t2_count", op_count, 16'd2);

    // Test 3: both held valid for four operations
    issue(0, 2'b00, 16'd1, 16'd2, 1'b0);
    issue(1, 2'b00, 16'd3, 16'd4, 1'b0);
    ng = 0;
    lowc = 0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      #1;
      if (!busy) lowc++;
      if (req_ready != 2'b00) begin
        grants[ng] = int'(req_ready);
        ng++;
      end
      tick;
    end
    req_valid = 2'b00;
    chk("t3_ngrants", 64'(ng), 64'd4);
    chk("t3_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]},
        8'b01_10_01_10);
    chk("t3_idle_cycles", 64'(lowc), 64'd4);
    wait_rsp(20);
    tick;
    chk("t3_count", op_count, 16'd6);

    // Test 4: backpressure with carry-in and 16-bit wrap
    rsp_ready = 2'b00;
    issue(0, 2'b00, 16'hFFFF, 16'h0001, 1'b1);
    tick;
    req_valid = 2'b00;
    wait_rsp(20);
    chk("t4_res", {rsp_result, rsp_flags}, {32'd1, 4'b0001});
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold_rsp", {rsp_valid, rsp_result}, {2'b01, 32'd1});
      chk("t4_hold_alu", {alu_d_a, alu_d_b, alu_op_code, alu_cin, alu_en_a, alu_en_b, alu_en_result},
          {16'hFFFF, 16'h0001, 2'b00, 1'b1, 3'b000});
      chk("t4_hold_ctl", {req_ready, op_count}, {2'b00, 16'd6});
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick;
    chk("t4_done", {rsp_valid, op_count, alu_d_a}, {2'b00, 16'd7, 16'd0});

    // Test 5: division by zero, then a normal division
    rsp_ready = 2'b10;
    issue(1, 2'b11, 16'd100, 16'd0, 1'b1);
    tick;
    req_valid = 2'b00;
    chk("t5_cb_masked", {alu_cin, alu_bin, alu_op_code}, 4'b0011);
    wait_rsp(20);
    chk("t5_div0", {rsp_valid, rsp_flags}, {2'b10, 4'b1000});
    tick;
    chk("t5_count0", op_count, 16'd8);
    issue(1, 2'b11, 16'd100, 16'd7, 1'b0);
    tick;
    req_valid = 2'b00;
    wait_rsp(20);
    chk("t5_div7", {rsp_result, rsp_remainder, rsp_flags}, {32'd14, 16'd2, 4'b0000});
    tick;
    chk("t5_count1", op_count, 16'd9);

    // Test 6: asynchronous reset during EXEC
    issue(0, 2'b00, 16'd5, 16'd6, 1'b0);
    tick;
    req_valid = 2'b00;
    tick;
    chk("t6_exec", alu_en_result, 1'b1);
    req_valid = 2'b11;
    rstn = 1'b0;
    #1;
    chk("t6_rst_en", {alu_en_a, alu_en_b, alu_en_result, rsp_valid, busy, req_ready}, 8'd0);
    chk("t6_rst_cnt", {op_count, alu_d_a}, 32'd0);
    tick;
    rstn = 1'b1;
    #1 chk("t6_first", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    wait_rsp(20);
    chk("t6_res", {rsp_valid, rsp_result}, {2'b01, 32'd11});
    rsp_ready = 2'b01;
    tick;
    chk("t6_count", op_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
